// File: rtl/alu_pkg.sv
// Shared constants for the ALU dispatch path: opcodes, input-word field layout
// and the dispatcher state encoding.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;

  localparam int OP_LSB    = 0;
  localparam int OP_W      = 2;
  localparam int ID_LSB    = 2;
  localparam int ID_W      = 8;
  localparam int DATA0_LSB = 10;
  localparam int DATA1_LSB = 26;
  localparam int DATA_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_POP   = 2'b01,
    ST_LOAD  = 2'b10,
    ST_ISSUE = 2'b11
  } state_t;

endpackage

// File: rtl/alu_credit_counter.sv
// Result-FIFO credit counter: reserve on pop, refund on drop, return on CSR pop.
// Returns beyond full are ignored and latch a sticky error.
module alu_credit_counter #(
  parameter int DEPTH        = 4,
  parameter int CREDIT_WIDTH = $clog2(DEPTH+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    reserve,
  input  logic                    refund,
  input  logic                    ret,
  output logic [CREDIT_WIDTH-1:0] credits,
  output logic                    credit_err
);

  localparam logic [CREDIT_WIDTH:0]   FULL_W = (CREDIT_WIDTH+1)'(DEPTH);
  localparam logic [CREDIT_WIDTH-1:0] FULL_C = CREDIT_WIDTH'(DEPTH);

  logic [CREDIT_WIDTH-1:0] r_credits;
  logic                    r_err;
  logic                    w_ret_ok;
  logic [CREDIT_WIDTH:0]   w_sum;
  logic [CREDIT_WIDTH-1:0] w_next;
  logic                    w_err_next;

  // Net credit change with clamp to full; reserve only occurs with credits > 0
  always_comb begin
    w_ret_ok   = ret && (r_credits != FULL_C);
    w_sum      = {1'b0, r_credits}
               + (CREDIT_WIDTH+1)'(refund)
               + (CREDIT_WIDTH+1)'(w_ret_ok)
               - (CREDIT_WIDTH+1)'(reserve);
    if (w_sum > FULL_W) begin
      w_next = FULL_C;
    end else begin
      w_next = w_sum[CREDIT_WIDTH-1:0];
    end
    if (ret && !w_ret_ok) begin
      w_err_next = 1'b1;
    end else begin
      w_err_next = r_err;
    end
  end

  // Credit and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credits <= FULL_C;
      r_err     <= 1'b0;
    end else begin
      r_credits <= w_next;
      r_err     <= w_err_next;
    end
  end

  assign credits    = r_credits;
  assign credit_err = r_err;

endmodule

// File: rtl/alu_dispatch_scheduler.sv
// Pops operation words from FIFO_IN, decodes them and issues ADD/MUL requests
// over valid/ready, gated by result-FIFO credits.
module alu_dispatch_scheduler
  import alu_pkg::*;
#(
  parameter int DATA_SIZE      = DATA_W,
  parameter int MUL_DATA_SIZE  = DATA_SIZE/2,
  parameter int ID_SIZE        = ID_W,
  parameter int OPERATION_SIZE = OP_W,
  parameter int FIFO_IN_WIDTH  = 2*DATA_SIZE+ID_SIZE+OPERATION_SIZE,
  parameter int FIFO_OUT_DEPTH = 4,
  parameter int CREDIT_WIDTH   = $clog2(FIFO_OUT_DEPTH+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     fifo_empty,
  input  logic [FIFO_IN_WIDTH-1:0] fifo_rdata,
  output logic                     fifo_r_en,
  output logic                     add_valid,
  input  logic                     add_ready,
  output logic [DATA_SIZE-1:0]     add_op1,
  output logic [DATA_SIZE-1:0]     add_op2,
  output logic [ID_SIZE-1:0]       add_id,
  output logic                     mul_valid,
  input  logic                     mul_ready,
  output logic [MUL_DATA_SIZE-1:0] mul_a,
  output logic [MUL_DATA_SIZE-1:0] mul_b,
  output logic [ID_SIZE-1:0]       mul_id,
  input  logic                     out_pop,
  output logic [CREDIT_WIDTH-1:0]  credits,
  output logic                     busy,
  output logic                     illegal_op,
  output logic [7:0]               drop_cnt,
  output logic                     credit_err
);

  state_t                   r_state, w_state;
  logic                     r_fifo_r_en, w_fifo_r_en;
  logic                     r_add_valid, w_add_valid;
  logic [DATA_SIZE-1:0]     r_add_op1, w_add_op1;
  logic [DATA_SIZE-1:0]     r_add_op2, w_add_op2;
  logic [ID_SIZE-1:0]       r_add_id, w_add_id;
  logic                     r_mul_valid, w_mul_valid;
  logic [MUL_DATA_SIZE-1:0] r_mul_a, w_mul_a;
  logic [MUL_DATA_SIZE-1:0] r_mul_b, w_mul_b;
  logic [ID_SIZE-1:0]       r_mul_id, w_mul_id;
  logic                     r_busy, w_busy;
  logic                     r_illegal_op, w_illegal_op;
  logic [7:0]               r_drop_cnt, w_drop_cnt;
  logic                     w_reserve, w_refund;

  logic [OPERATION_SIZE-1:0] w_op;
  logic [ID_SIZE-1:0]        w_id;
  logic [DATA_SIZE-1:0]      w_data0, w_data1;

  assign w_op    = fifo_rdata[OP_LSB +: OPERATION_SIZE];
  assign w_id    = fifo_rdata[ID_LSB +: ID_SIZE];
  assign w_data0 = fifo_rdata[DATA0_LSB +: DATA_SIZE];
  assign w_data1 = fifo_rdata[DATA1_LSB +: DATA_SIZE];

  alu_credit_counter #(
    .DEPTH        (FIFO_OUT_DEPTH),
    .CREDIT_WIDTH (CREDIT_WIDTH)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .reserve    (w_reserve),
    .refund     (w_refund),
    .ret        (out_pop),
    .credits    (credits),
    .credit_err (credit_err)
  );

  // Next-state and next-output decode; payload holds unless reloaded
  always_comb begin
    w_state      = r_state;
    w_fifo_r_en  = 1'b0;
    w_add_valid  = r_add_valid;
    w_add_op1    = r_add_op1;
    w_add_op2    = r_add_op2;
    w_add_id     = r_add_id;
    w_mul_valid  = r_mul_valid;
    w_mul_a      = r_mul_a;
    w_mul_b      = r_mul_b;
    w_mul_id     = r_mul_id;
    w_illegal_op = 1'b0;
    w_drop_cnt   = r_drop_cnt;
    w_reserve    = 1'b0;
    w_refund     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && !fifo_empty && (credits != {CREDIT_WIDTH{1'b0}})) begin
          w_state     = ST_POP;
          w_fifo_r_en = 1'b1;
          w_reserve   = 1'b1;
        end else begin
          w_state = ST_IDLE;
        end
      end
      ST_POP: begin
        w_state = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_op == OP_ADD) begin
          w_add_op1   = w_data0;
          w_add_op2   = w_data1;
          w_add_id    = w_id;
          w_add_valid = 1'b1;
          w_state     = ST_ISSUE;
        end else if (w_op == OP_MUL) begin
          w_mul_a     = w_data0[MUL_DATA_SIZE-1:0];
          w_mul_b     = w_data1[MUL_DATA_SIZE-1:0];
          w_mul_id    = w_id;
          w_mul_valid = 1'b1;
          w_state     = ST_ISSUE;
        end else begin
          // Dropped op gives its reserved result slot back
          w_illegal_op = 1'b1;
          w_refund     = 1'b1;
          if (r_drop_cnt != 8'hFF) begin
            w_drop_cnt = r_drop_cnt + 8'd1;
          end else begin
            w_drop_cnt = r_drop_cnt;
          end
          w_state = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if ((r_add_valid && add_ready) || (r_mul_valid && mul_ready)) begin
          w_add_valid = 1'b0;
          w_mul_valid = 1'b0;
          w_state     = ST_IDLE;
        end else begin
          w_state = ST_ISSUE;
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
    w_busy = (w_state != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_fifo_r_en  <= 1'b0;
      r_add_valid  <= 1'b0;
      r_add_op1    <= {DATA_SIZE{1'b0}};
      r_add_op2    <= {DATA_SIZE{1'b0}};
      r_add_id     <= {ID_SIZE{1'b0}};
      r_mul_valid  <= 1'b0;
      r_mul_a      <= {MUL_DATA_SIZE{1'b0}};
      r_mul_b      <= {MUL_DATA_SIZE{1'b0}};
      r_mul_id     <= {ID_SIZE{1'b0}};
      r_busy       <= 1'b0;
      r_illegal_op <= 1'b0;
      r_drop_cnt   <= 8'd0;
    end else begin
      r_state      <= w_state;
      r_fifo_r_en  <= w_fifo_r_en;
      r_add_valid  <= w_add_valid;
      r_add_op1    <= w_add_op1;
      r_add_op2    <= w_add_op2;
      r_add_id     <= w_add_id;
      r_mul_valid  <= w_mul_valid;
      r_mul_a      <= w_mul_a;
      r_mul_b      <= w_mul_b;
      r_mul_id     <= w_mul_id;
      r_busy       <= w_busy;
      r_illegal_op <= w_illegal_op;
      r_drop_cnt   <= w_drop_cnt;
    end
  end

  assign fifo_r_en  = r_fifo_r_en;
  assign add_valid  = r_add_valid;
  assign add_op1    = r_add_op1;
  assign add_op2    = r_add_op2;
  assign add_id     = r_add_id;
  assign mul_valid  = r_mul_valid;
  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign mul_id     = r_mul_id;
  assign busy       = r_busy;
  assign illegal_op = r_illegal_op;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_alu_dispatch_scheduler.sv
// Directed bench for alu_dispatch_scheduler: a timeline model of each op's
// lifetime checked every cycle, plus hand-computed literal expectations.
module tb_alu_dispatch_scheduler;

  localparam int DEPTH = 4;
  localparam int FW    = 42;

  logic          clk = 1'b0;
  logic          rst, enable, fifo_empty, add_ready, mul_ready, out_pop;
  logic [FW-1:0] fifo_rdata;
  logic          fifo_r_en, add_valid, mul_valid, busy, illegal_op, credit_err;
  logic [15:0]   add_op1, add_op2;
  logic [7:0]    add_id, mul_a, mul_b, mul_id, drop_cnt;
  logic [2:0]    credits;

  always #5 clk = ~clk;

  alu_dispatch_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata), .fifo_r_en(fifo_r_en),
    .add_valid(add_valid), .add_ready(add_ready), .add_op1(add_op1),
    .add_op2(add_op2), .add_id(add_id),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_a(mul_a),
    .mul_b(mul_b), .mul_id(mul_id),
    .out_pop(out_pop), .credits(credits), .busy(busy),
    .illegal_op(illegal_op), .drop_cnt(drop_cnt), .credit_err(credit_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [FW-1:0] q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [1:0] op, input logic [7:0] id,
                                       input logic [15:0] d0, input logic [15:0] d1);
    return {d1, d0, id, op};
  endfunction

  // Model: an op's age counts edges since its credit was reserved (-1 = none)
  int          m_age = -1;
  int          m_cred = DEPTH;
  int          m_drop = 0;
  int          m_nc;
  bit          m_err = 1'b0, m_ill = 1'b0, m_av = 1'b0, m_mv = 1'b0;
  bit          m_rsv, m_rfd;
  logic [15:0] m_op1 = 16'd0, m_op2 = 16'd0;
  logic [7:0]  m_aid = 8'd0, m_a = 8'd0, m_b = 8'd0, m_mid = 8'd0;

  always @(posedge clk) begin
    m_rsv = 1'b0;
    m_rfd = 1'b0;
    if (rst) begin
      m_age = -1; m_cred = DEPTH; m_drop = 0; m_err = 1'b0; m_ill = 1'b0;
      m_av = 1'b0; m_mv = 1'b0;
      m_op1 = 16'd0; m_op2 = 16'd0; m_aid = 8'd0; m_a = 8'd0; m_b = 8'd0; m_mid = 8'd0;
    end else begin
      m_ill = 1'b0;
      if (m_age == -1) begin
        if (enable && !fifo_empty && m_cred > 0) begin
          m_rsv = 1'b1;
          m_age = 1;
        end
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (m_age == 2) begin
        if (fifo_rdata[1:0] == 2'd0) begin
          m_av = 1'b1; m_op1 = fifo_rdata[25:10]; m_op2 = fifo_rdata[41:26];
          m_aid = fifo_rdata[9:2]; m_age = 3;
        end else if (fifo_rdata[1:0] == 2'd1) begin
          m_mv = 1'b1; m_a = fifo_rdata[17:10]; m_b = fifo_rdata[33:26];
          m_mid = fifo_rdata[9:2]; m_age = 3;
        end else begin
          m_ill = 1'b1; m_rfd = 1'b1; m_age = -1;
          m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end
      end else if ((m_av && add_ready) || (m_mv && mul_ready)) begin
        m_av = 1'b0; m_mv = 1'b0; m_age = -1;
      end
      m_nc = m_cred - int'(m_rsv) + int'(m_rfd);
      if (out_pop) begin
        if (m_cred == DEPTH) m_err = 1'b1;
        else m_nc = m_nc + 1;
      end
      m_cred = (m_nc > DEPTH) ? DEPTH : m_nc;
    end
    #1;
    chk("fifo_r_en", fifo_r_en, m_age == 1);
    chk("add_valid", add_valid, m_av);
    chk("mul_valid", mul_valid, m_mv);
    chk("valid_excl", add_valid & mul_valid, 1'b0);
    chk("credits", credits, m_cred);
    chk("busy", busy, m_age != -1);
    chk("illegal_op", illegal_op, m_ill);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("credit_err", credit_err, m_err);
    if (m_av) begin
      chk("add_op1", add_op1, m_op1);
      chk("add_op2", add_op2, m_op2);
      chk("add_id", add_id, m_aid);
    end
    if (m_mv) begin
      chk("mul_a", mul_a, m_a);
      chk("mul_b", mul_b, m_b);
      chk("mul_id", mul_id, m_mid);
    end
  end

  // One cycle of the FIFO_IN environment: read data follows a pop strobe
  task automatic tick();
    @(negedge clk);
    if (fifo_r_en && q.size() > 0) fifo_rdata = q.pop_front();
    fifo_empty = (q.size() == 0);
  endtask

  task automatic push(input logic [FW-1:0] w);
    q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic give_credit(input int n);
    out_pop = 1'b1;
    for (int i = 0; i < n; i++) tick();
    out_pop = 1'b0;
  endtask

  initial begin
    int k, ren_cnt, issued, ill_cnt, vcnt;
    rst = 1'b1; enable = 1'b0; fifo_empty = 1'b1; fifo_rdata = '0;
    add_ready = 1'b0; mul_ready = 1'b0; out_pop = 1'b0;
    repeat (3) tick();
    chk("rst_credits", credits, 3'd4);
    chk("rst_busy", busy, 1'b0);
    chk("rst_add_op1", add_op1, 16'd0);
    chk("rst_mul_id", mul_id, 8'd0);
    rst = 1'b0;
    tick();

    // Single ADD, ready already high
    enable = 1'b1; add_ready = 1'b1;
    push(mk(2'b00, 8'h5A, 16'h1234, 16'h0F0F));
    ren_cnt = 0;
    for (k = 0; k < 20 && !add_valid; k++) begin
      tick();
      if (fifo_r_en) ren_cnt++;
    end
    chk("t1_valid_seen", add_valid, 1'b1);
    chk("t1_ren_cycles", ren_cnt, 1);
    chk("t1_op1", add_op1, 16'h1234);
    chk("t1_op2", add_op2, 16'h0F0F);
    chk("t1_id", add_id, 8'h5A);
    chk("t1_credits", credits, 3'd3);
    tick();
    chk("t1_valid_1cyc", add_valid, 1'b0);
    give_credit(1);

    // MUL held by mul_ready low for 5 cycles
    push(mk(2'b01, 8'h11, 16'hAB07, 16'hCD09));
    for (k = 0; k < 20 && !mul_valid; k++) tick();
    for (int i = 0; i < 6; i++) begin
      chk("t2_mul_valid", mul_valid, 1'b1);
      chk("t2_mul_a", mul_a, 8'h07);
      chk("t2_mul_b", mul_b, 8'h09);
      chk("t2_mul_id", mul_id, 8'h11);
      chk("t2_no_add", add_valid, 1'b0);
      if (i == 5) mul_ready = 1'b1;
      tick();
    end
    chk("t2_mul_done", mul_valid, 1'b0);
    mul_ready = 1'b0;
    give_credit(1);

    // Five ADDs against four credits
    for (int i = 0; i < 5; i++) push(mk(2'b00, 8'h20 + 8'(i), 16'(i), 16'(i * 3)));
    issued = 0;
    for (k = 0; k < 30; k++) begin
      tick();
      if (add_valid && add_ready) begin
        chk("t3_id", add_id, 32'h20 + issued);
        issued++;
      end
    end
    chk("t3_issued4", issued, 4);
    chk("t3_credits0", credits, 3'd0);
    chk("t3_left", q.size(), 1);
    give_credit(1);
    for (k = 0; k < 15; k++) begin
      tick();
      if (add_valid && add_ready) begin
        chk("t3_id5", add_id, 32'h20 + issued);
        issued++;
      end
    end
    chk("t3_issued5", issued, 5);
    chk("t3_credits_end", credits, 3'd0);
    give_credit(4);
    chk("t3_restored", credits, 3'd4);

    // Illegal opcode is dropped and refunded
    push(mk(2'b11, 8'h33, 16'hBEEF, 16'h0001));
    ill_cnt = 0; vcnt = 0;
    for (k = 0; k < 10; k++) begin
      tick();
      if (illegal_op) ill_cnt++;
      if (add_valid || mul_valid) vcnt++;
    end
    chk("t4_pulses", ill_cnt, 1);
    chk("t4_no_valid", vcnt, 0);
    chk("t4_drop", drop_cnt, 8'd1);
    chk("t4_credits", credits, 3'd4);
    push(mk(2'b00, 8'h44, 16'h0042, 16'h0043));
    for (k = 0; k < 10 && !add_valid; k++) tick();
    chk("t4_next_id", add_id, 8'h44);
    chk("t4_next_op1", add_op1, 16'h0042);
    tick();
    give_credit(1);

    // Reserve and return on the same edge, then return at full
    push(mk(2'b00, 8'h50, 16'h1, 16'h2));
    push(mk(2'b00, 8'h51, 16'h3, 16'h4));
    repeat (12) tick();
    chk("t5_credits2", credits, 3'd2);
    push(mk(2'b00, 8'h55, 16'h5, 16'h6));
    out_pop = 1'b1;
    tick();
    out_pop = 1'b0;
    chk("t5_same_edge", credits, 3'd2);
    chk("t5_popping", fifo_r_en, 1'b1);
    repeat (6) tick();
    chk("t5_after_issue", credits, 3'd2);
    give_credit(2);
    chk("t5_full", credits, 3'd4);
    chk("t5_no_err", credit_err, 1'b0);
    give_credit(1);
    chk("t5_over_credits", credits, 3'd4);
    chk("t5_over_err", credit_err, 1'b1);

    // Reset while an ADD waits for ready, then disabled dispatch
    add_ready = 1'b0;
    push(mk(2'b00, 8'h66, 16'h7, 16'h8));
    for (k = 0; k < 10 && !add_valid; k++) tick();
    chk("t6_waiting", add_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    enable = 1'b0;
    chk("t6_valid", add_valid, 1'b0);
    chk("t6_credits", credits, 3'd4);
    chk("t6_busy", busy, 1'b0);
    chk("t6_drop", drop_cnt, 8'd0);
    chk("t6_err", credit_err, 1'b0);
    chk("t6_op1", add_op1, 16'd0);
    push(mk(2'b00, 8'h77, 16'h9, 16'hA));
    ren_cnt = 0;
    for (k = 0; k < 8; k++) begin
      tick();
      if (fifo_r_en) ren_cnt++;
    end
    chk("t6_no_pop", ren_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
